// File: rtl/receive_deserializer.sv
// Serial receiver for 15-bit frames: a start bit, 12 data bits sent LSB first,
// an even-parity bit and a stop bit. The line is sampled once per bit, at the
// middle of that bit.
module receive_deserializer #(
  parameter int BIT_CYCLES = 4,
  parameter int HALF       = BIT_CYCLES / 2
) (
  input  logic        clk,
  input  logic        ctr_clr,
  input  logic        conv_en_n,
  input  logic        ser_in,
  output logic [11:0] reg_out,
  output logic        data_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  word_cnt
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [11:0]   sreg;
  logic          par_bit;
  logic          tick, shift, par_ld, accept, ferr;

  // The start bit is sampled half a bit in; every later bit is sampled one full
  // bit period after the previous sample.
  assign tick = (state == START) ? (cnt == CW'(HALF - 1)) : (cnt == CW'(BIT_CYCLES - 1));
  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (ctr_clr) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and per-sample strobes; a disable while busy overrides all of them
  always_comb begin
    state_nx = state;
    shift    = 1'b0;
    par_ld   = 1'b0;
    accept   = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE:      if (!conv_en_n && !ser_in) state_nx = START;
      START:     if (tick) state_nx = ser_in ? IDLE : DATA;
      DATA:      if (tick) begin
                   shift = 1'b1;
                   if (bit_idx == 4'd11) state_nx = PARITY;
                 end
      PARITY:    if (tick) begin
                   par_ld   = 1'b1;
                   state_nx = STOP;
                 end
      STOP:      if (tick) begin
                   accept   = ser_in;
                   ferr     = !ser_in;
                   state_nx = ser_in ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (ser_in) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (state != IDLE && conv_en_n) begin
      state_nx = IDLE;
      shift    = 1'b0;
      par_ld   = 1'b0;
      accept   = 1'b0;
      ferr     = 1'b0;
    end
  end

  // Bit timing counter, shift register and bit index
  always_ff @(posedge clk) begin
    if (ctr_clr) begin
      cnt     <= '0;
      bit_idx <= '0;
      sreg    <= '0;
      par_bit <= 1'b0;
    end else begin
      cnt <= (tick || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      if (shift) begin
        sreg    <= {ser_in, sreg[11:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (par_ld) par_bit <= ser_in;
    end
  end

  // Result registers: updated only on a good stop bit; strobes last one cycle
  always_ff @(posedge clk) begin
    if (ctr_clr) begin
      reg_out    <= '0;
      parity_err <= 1'b0;
      word_cnt   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= accept;
      frame_err  <= ferr;
      if (accept) begin
        reg_out    <= sreg;
        parity_err <= (^sreg) ^ par_bit;
        word_cnt   <= word_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_receive_deserializer.sv
// Scoreboard bench: the stimulus pushes the expected word and the cycle it should
// appear in; a monitor pops and compares each data_valid or frame_err pulse.
module tb_receive_deserializer;

  localparam int BC   = 4;
  localparam int HALF = BC / 2;
  localparam int STOP_OFS = HALF + 14 * BC;

  typedef struct {
    logic [11:0] data;
    logic        perr;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        ctr_clr = 1'b1;
  logic        conv_en_n = 1'b1;
  logic        ser_in = 1'b1;
  logic [11:0] reg_out;
  logic        data_valid, parity_err, frame_err, busy;
  logic [7:0]  word_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   dv_pulses = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  exp_t sq[$];
  int   fq[$];

  receive_deserializer #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .ctr_clr(ctr_clr), .conv_en_n(conv_en_n), .ser_in(ser_in),
    .reg_out(reg_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue
  always @(negedge clk) begin
    chk("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    if (data_valid) begin
      dv_pulses++;
      chk("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
      if (sq.size() == 0) chk("dv_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("reg_out", {20'd0, reg_out}, {20'd0, e.data});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        chk("word_cnt", {24'd0, word_cnt}, {24'd0, e.cnt});
        chk("dv_cycle", cyc, e.cyc);
      end
    end
    if (frame_err) begin
      chk("fe_one_cycle", {31'd0, prev_fe}, 32'd0);
      if (fq.size() == 0) chk("fe_unexpected", 32'd1, 32'd0);
      else chk("fe_cycle", cyc, fq.pop_front());
    end
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  // Drive one full frame starting at the next edge (E0); returns with the line
  // still at the stop level, 15*BC edges later.
  task automatic send_frame(input logic [11:0] d, input logic p, input logic stopb);
    logic [14:0] bits;
    exp_t e;
    int e0;
    bits = {stopb, p, d, 1'b0};
    e0 = cyc + 1;
    if (stopb) begin
      exp_cnt++;
      e.data = d; e.perr = (^d) ^ p; e.cnt = exp_cnt; e.cyc = e0 + STOP_OFS;
      sq.push_back(e);
    end else fq.push_back(e0 + STOP_OFS);
    for (int k = 0; k < 15; k++) begin
      ser_in = bits[k];
      repeat (BC) @(negedge clk);
    end
  endtask

  // Drive start bit plus the first n data bits of d
  task automatic partial_frame(input logic [11:0] d, input int n);
    ser_in = 1'b0;
    repeat (BC) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      ser_in = d[k];
      repeat (BC) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] w;
    repeat (3) @(negedge clk);
    chk("rst_reg_out", {20'd0, reg_out}, 32'd0);
    chk("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    ctr_clr = 1'b0;
    conv_en_n = 1'b0;
    repeat (2) @(negedge clk);

    // good frame, then a parity error that is still delivered
    send_frame(12'hA5C, 1'b0, 1'b1);
    send_frame(12'hFFF, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // one-clock glitch: START at E0, back to IDLE at E0+2
    ser_in = 1'b0;
    @(negedge clk);
    ser_in = 1'b1;
    chk("glitch_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("glitch_busy_e1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("glitch_busy_e2", {31'd0, busy}, 32'd0);
    chk("glitch_reg_out", {20'd0, reg_out}, 32'h0FFF);
    repeat (3) @(negedge clk);

    // framing error: line stays low ten clocks past the parity bit
    send_frame(12'h123, ^12'h123, 1'b0);
    repeat (6) @(negedge clk);
    chk("ferr_busy_low", {31'd0, busy}, 32'd1);
    chk("ferr_reg_out", {20'd0, reg_out}, 32'h0FFF);
    chk("ferr_word_cnt", {24'd0, word_cnt}, {24'd0, exp_cnt});
    ser_in = 1'b1;
    @(negedge clk);
    chk("ferr_idle", {31'd0, busy}, 32'd0);
    send_frame(12'h456, ^12'h456, 1'b1);
    repeat (2) @(negedge clk);

    // disable during data bit 5
    partial_frame(12'h3C7, 5);
    ser_in = 1'b1;
    @(negedge clk);
    conv_en_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (70) @(negedge clk);
    chk("abort_word_cnt", {24'd0, word_cnt}, {24'd0, exp_cnt});
    chk("abort_reg_out", {20'd0, reg_out}, 32'h0456);
    conv_en_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-frame
    partial_frame(12'h9A1, 7);
    ctr_clr = 1'b1;
    @(negedge clk);
    ctr_clr = 1'b0;
    ser_in = 1'b1;
    exp_cnt = 8'd0;
    chk("clr_reg_out", {20'd0, reg_out}, 32'd0);
    chk("clr_word_cnt", {24'd0, word_cnt}, 32'd0);
    chk("clr_parity_err", {31'd0, parity_err}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    repeat (70) @(negedge clk);
    chk("clr_no_late_dv", {24'd0, word_cnt}, 32'd0);

    // 256 back-to-back frames: counter wraps to zero
    dv_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      w = 12'(i * 37 + 5);
      send_frame(w, ^w, 1'b1);
    end
    repeat (3) @(negedge clk);
    chk("wrap_word_cnt", {24'd0, word_cnt}, 32'd0);
    chk("wrap_dv_pulses", dv_pulses, 256);
    chk("sq_drained", sq.size(), 0);
    chk("fq_drained", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receive_deserializer.md
RECEIVE_DESERIALIZER -- requirements
Module: receive_deserializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, meaning clocks per serial bit; it must be even and >= 2.
REQ-002 SHALL have parameter HALF, default BIT_CYCLES/2, meaning mid-bit sample offset; it is derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ctr_clr, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port conv_en_n, input, 1 bit: active-low receiver enable.
REQ-006 SHALL have port ser_in, input, 1 bit: serial line, idle high.
REQ-007 SHALL have port reg_out, output, 12 bits: last received data word.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle pulse on a new reg_out.
REQ-009 SHALL have port parity_err, output, 1 bit: parity flag of the last accepted word.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port busy, output, 1 bit: high when not in IDLE.
REQ-012 SHALL have port word_cnt, output, 8 bits: count of accepted words.

Function
REQ-013 SHALL accept frames of: start bit 0, 12 data bits LSB first, parity bit, stop bit 1, each bit BIT_CYCLES clocks long.
REQ-014 SHALL use even parity: parity_err=1 when popcount(data)+parity bit is odd.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; busy=1 in every state except IDLE.
REQ-016 SHALL move IDLE->START at edge E0 where conv_en_n=0 and ser_in=0; the bit-period counter is 0 after E0.
REQ-017 SHALL sample the start bit at E0+HALF: 1 -> IDLE (glitch rejected, no outputs change); 0 -> DATA.
REQ-018 SHALL sample data bit i (i=0..11) at E0+HALF+(i+1)*BIT_CYCLES, shifting it in LSB first; after bit 11 -> PARITY.
REQ-019 SHALL sample parity at E0+HALF+13*BIT_CYCLES -> STOP, and sample stop at E0+HALF+14*BIT_CYCLES.
REQ-020 SHALL, on stop=1, update reg_out, parity_err and word_cnt on the stop-sample edge, assert data_valid for exactly the following cycle, and -> IDLE.
REQ-021 SHALL give, for BIT_CYCLES=4, the stop sample at E0+58 with data_valid high from E58 to E59.
REQ-022 SHALL, on stop=0, pulse frame_err for one cycle, leave reg_out/parity_err/word_cnt unchanged, and -> WAIT_IDLE.
REQ-023 SHALL leave WAIT_IDLE for IDLE on the first edge where ser_in=1.
REQ-024 SHALL, when a parity error occurs, still deliver the word: reg_out updated, data_valid pulsed, word_cnt incremented, parity_err=1.
REQ-025 SHALL increment word_cnt once per data_valid and wrap 255->0.
REQ-026 SHALL make the earliest next start detection possible at the edge after the stop-sample edge.
REQ-027 SHALL, if conv_en_n=1 at any edge while busy, go to IDLE, discard the partial word, and assert no data_valid or frame_err; conv_en_n=1 in IDLE holds IDLE.
REQ-028 SHALL hold reg_out, parity_err and word_cnt between accepted words; data_valid and frame_err are never high in the same cycle.

Reset
REQ-029 SHALL, at an edge with ctr_clr=1, set state IDLE, reg_out=12'h000, data_valid=0, parity_err=0, frame_err=0, busy=0, word_cnt=0, and clear the shift register and counters.
REQ-030 SHALL give ctr_clr priority over all other inputs, including mid-frame; the partial frame is discarded with no pulse.
REQ-031 SHALL resume operation on the first edge after ctr_clr deasserts (start detection possible at that edge).

Verification
REQ-032 SHALL cover a good frame, BIT_CYCLES=4, data 12'hA5C, parity 0, stop 1 -> reg_out=12'hA5C, parity_err=0, data_valid one cycle at E0+58..59, word_cnt=1.
REQ-033 SHALL cover a parity error: data 12'hFFF, parity 1 -> reg_out=12'hFFF, parity_err=1, data_valid pulsed, word_cnt incremented.
REQ-034 SHALL cover a glitch: ser_in low for 1 clock only, in IDLE -> back to IDLE at E0+2, no data_valid, reg_out unchanged.
REQ-035 SHALL cover a framing error: data 12'h123, stop 0, line held low 10 clocks -> frame_err one-cycle pulse, reg_out unchanged, busy=1 until ser_in returns high, then a next good frame 12'h456 is received correctly.
REQ-036 SHALL cover abort and reset: conv_en_n=1 at data bit 5 -> busy=0 next cycle, no pulses; ctr_clr=1 mid-frame -> all outputs at reset values.
REQ-037 SHALL cover counter wrap: 256 good frames back-to-back -> word_cnt returns to 0, with exactly 256 data_valid pulses.
